// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: instruction classes,
// sequencer states and default widths.
package pc_seq_pkg;

  localparam int PC_W_DEFAULT     = 10;
  localparam int RS_DEPTH_DEFAULT = 4;

  typedef enum logic [3:0] {
    OP_SEQ  = 4'd0,
    OP_BIZR = 4'd1,
    OP_BNZR = 4'd2,
    OP_JIZR = 4'd3,
    OP_JNZR = 4'd4,
    OP_JSR  = 4'd5,
    OP_RET  = 4'd6,
    OP_LJ0  = 4'd7,
    OP_LJ1  = 4'd8,
    OP_LJ2  = 4'd9,
    OP_LJ3  = 4'd10,
    OP_HALT = 4'd11
  } op_class_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address stack: push/pop with full/empty flags and a combinational
// top-of-stack view (0 when empty). Clear resets only the pointer.
module pc_ret_stack
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH_DEFAULT,
  parameter int W     = PC_W_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_top,
  output logic         o_full,
  output logic         o_empty
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);

  logic [W-1:0]   r_mem [DEPTH];
  logic [SPW-1:0] r_sp;
  logic [AW-1:0]  w_wr_idx;
  logic [AW-1:0]  w_rd_idx;

  assign w_wr_idx = AW'(r_sp);
  assign w_rd_idx = AW'(r_sp - SPW'(1));
  assign o_full   = (r_sp == SPW'(DEPTH));
  assign o_empty  = (r_sp == {SPW{1'b0}});
  assign o_top    = o_empty ? {W{1'b0}} : r_mem[w_rd_idx];

  // Stack pointer and entries; entries survive a clear so they stay readable for debug.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sp <= {SPW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {W{1'b0}};
      end
    end else if (i_clr) begin
      r_sp <= {SPW{1'b0}};
    end else if (i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_din;
      r_sp            <= r_sp + SPW'(1);
    end else if (i_pop && !o_empty) begin
      r_sp <= r_sp - SPW'(1);
    end else begin
      r_sp <= r_sp;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Control sequencer for program_counter: run/halt/fault lifecycle, branch/jump
// decode and call/return link. Optional retired-op counter: PC_SEQ_INSTR_COUNT_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEFAULT,
  parameter int PC_W     = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            go,
  input  logic [3:0]      op_class,
  input  logic            zero,
  input  logic [PC_W-1:0] rp,
  output logic            start,
  output logic            branch,
  output logic            bizr,
  output logic            bnzr,
  output logic            jizr,
  output logic            jnzr,
  output logic            jump2sub,
  output logic            retFsub,
  output logic            lj0,
  output logic            lj1,
  output logic            lj2,
  output logic            lj3,
  output logic [PC_W-1:0] rl,
  output logic            busy,
  output logic            done,
  output logic            fault,
  output logic [15:0]     instr_count
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_push;
  logic            w_pop;
  logic            w_clr;
  logic            w_retire;
  logic            w_full;
  logic            w_empty;
  logic [PC_W-1:0] w_link;

  assign w_link = rp + PC_W'(1);

  pc_ret_stack #(.DEPTH(RS_DEPTH), .W(PC_W)) u_stack (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_link),
    .o_top   (rl),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and control decode; RUN outputs follow op_class/zero/sp in the same cycle.
  always_comb begin
    start       = 1'b0;
    branch      = 1'b0;
    bizr        = 1'b0;
    bnzr        = 1'b0;
    jizr        = 1'b0;
    jnzr        = 1'b0;
    jump2sub    = 1'b0;
    retFsub     = 1'b0;
    lj0         = 1'b0;
    lj1         = 1'b0;
    lj2         = 1'b0;
    lj3         = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clr       = 1'b0;
    w_retire    = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (go) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_START: begin
        start       = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_retire = 1'b1;
        case (op_class)
          OP_SEQ:  w_retire = 1'b1;
          OP_BIZR: begin branch = zero;  bizr = zero;  end
          OP_JIZR: begin branch = zero;  jizr = zero;  end
          OP_BNZR: begin branch = !zero; bnzr = !zero; end
          OP_JNZR: begin branch = !zero; jnzr = !zero; end
          OP_LJ0:  lj0 = 1'b1;
          OP_LJ1:  lj1 = 1'b1;
          OP_LJ2:  lj2 = 1'b1;
          OP_LJ3:  lj3 = 1'b1;
          OP_JSR: begin
            if (!w_full) begin
              jump2sub = 1'b1;
              w_push   = 1'b1;
            end else begin
              w_retire    = 1'b0;
              w_state_nxt = ST_FAULT;
            end
          end
          OP_RET: begin
            if (!w_empty) begin
              retFsub = 1'b1;
              w_pop   = 1'b1;
            end else begin
              w_retire    = 1'b0;
              w_state_nxt = ST_FAULT;
            end
          end
          OP_HALT: w_state_nxt = ST_DONE;
          default: begin
            w_retire    = 1'b0;
            w_state_nxt = ST_FAULT;
          end
        endcase
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy  = (r_state == ST_START) || (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign fault = (r_state == ST_FAULT);

`ifdef PC_SEQ_INSTR_COUNT_EN
  logic [15:0] r_instr_count;

  // Retired-op counter: zeroed on launch, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_count <= 16'h0000;
    end else if (w_clr) begin
      r_instr_count <= 16'h0000;
    end else if (w_retire && (r_instr_count != 16'hFFFF)) begin
      r_instr_count <= r_instr_count + 16'h0001;
    end else begin
      r_instr_count <= r_instr_count;
    end
  end

  assign instr_count = r_instr_count;
`else
  logic w_unused_retire;

  assign w_unused_retire = w_retire;
  assign instr_count     = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a queue-based reference model compared
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int RS = 4;
  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic [3:0]    op_class;
  logic          zero;
  logic [PW-1:0] rp;
  logic start, branch, bizr, bnzr, jizr, jnzr, jump2sub, retFsub;
  logic lj0, lj1, lj2, lj3, busy, done, fault;
  logic [PW-1:0] rl;
  logic [15:0]   instr_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 idle, 1 start, 2 run, 3 done, 4 fault.
  int            m_ph  = 0;
  int            m_cnt = 0;
  logic [PW-1:0] m_stk[$];

  wire [11:0] w_ctrl = {start, branch, bizr, bnzr, jizr, jnzr, jump2sub, retFsub, lj0, lj1, lj2, lj3};

  always #5 clk = ~clk;

  pc_sequencer #(.RS_DEPTH(RS), .PC_W(PW)) dut (
    .clk(clk), .reset(reset), .go(go), .op_class(op_class), .zero(zero), .rp(rp),
    .start(start), .branch(branch), .bizr(bizr), .bnzr(bnzr), .jizr(jizr), .jnzr(jnzr),
    .jump2sub(jump2sub), .retFsub(retFsub), .lj0(lj0), .lj1(lj1), .lj2(lj2), .lj3(lj3),
    .rl(rl), .busy(busy), .done(done), .fault(fault), .instr_count(instr_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Control vector bits: start,branch,bizr,bnzr,jizr,jnzr,jump2sub,retFsub,lj0..lj3.
  function automatic logic [11:0] exp_ctrl(int ph, int sz, int op, logic z);
    if (ph == 1) return 12'h800;
    if (ph != 2) return 12'h000;
    case (op)
      1:  return z  ? 12'h600 : 12'h000;
      2:  return !z ? 12'h500 : 12'h000;
      3:  return z  ? 12'h480 : 12'h000;
      4:  return !z ? 12'h440 : 12'h000;
      5:  return (sz < RS) ? 12'h020 : 12'h000;
      6:  return (sz > 0)  ? 12'h010 : 12'h000;
      7:  return 12'h008;
      8:  return 12'h004;
      9:  return 12'h002;
      10: return 12'h001;
      default: return 12'h000;
    endcase
  endfunction

  function automatic bit op_faults(int op, int sz);
    return (op >= 12) || (op == 5 && sz == RS) || (op == 6 && sz == 0);
  endfunction

  // Compare against the model, then advance the model over the coming clock edge.
  always @(negedge clk) begin
    if (reset) begin
      m_ph  = 0;
      m_cnt = 0;
      m_stk.delete();
    end else begin
      int sz;
      int op;
      logic [PW-1:0] e_rl;
      logic [15:0]   e_cnt;
      sz    = m_stk.size();
      op    = int'(op_class);
      e_rl  = (sz > 0) ? m_stk[sz-1] : '0;
`ifdef PC_SEQ_INSTR_COUNT_EN
      e_cnt = 16'(m_cnt);
`else
      e_cnt = 16'h0000;
`endif
      chk("ctrl",  32'(w_ctrl), 32'(exp_ctrl(m_ph, sz, op, zero)));
      chk("rl",    32'(rl), 32'(e_rl));
      chk("busy",  32'(busy),  32'(m_ph == 1 || m_ph == 2));
      chk("done",  32'(done),  32'(m_ph == 3));
      chk("fault", 32'(fault), 32'(m_ph == 4));
      chk("icount", 32'(instr_count), 32'(e_cnt));
      case (m_ph)
        0, 3, 4: if (go) begin m_ph = 1; m_cnt = 0; m_stk.delete(); end
        1: m_ph = 2;
        2: begin
          if (op_faults(op, sz)) begin
            m_ph = 4;
          end else begin
            if (op == 5) m_stk.push_back(PW'((int'(rp) + 1) % (1 << PW)));
            if (op == 6) void'(m_stk.pop_back());
            if (op == 11) m_ph = 3;
            if (m_cnt < 65535) m_cnt++;
          end
        end
        default: m_ph = 0;
      endcase
    end
  end

  task automatic cyc(input logic [3:0] op, input logic z, input logic [PW-1:0] p, input logic g);
    @(posedge clk);
    #1;
    op_class = op;
    zero     = z;
    rp       = p;
    go       = g;
    @(negedge clk);
    #1;
  endtask

  task automatic launch();
    cyc(OP_SEQ, 1'b0, 10'h000, 1'b1);
    cyc(OP_SEQ, 1'b0, 10'h000, 1'b0);
    chk("start_pulse", 32'(start), 32'd1);
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; op_class = 4'd0; zero = 1'b0; rp = '0;
    #11;
    chk("rst_ctrl", 32'(w_ctrl), 32'd0);
    chk("rst_rl", 32'(rl), 32'd0);
    chk("rst_status", 32'({busy, done, fault}), 32'd0);
    chk("rst_icount", 32'(instr_count), 32'd0);
    #1 reset = 1'b0;

    // Launch and decode
    launch();
    chk("start_busy", 32'(busy), 32'd1);
    cyc(OP_SEQ, 1'b0, 10'h000, 1'b0);
    chk("seq_ctrl", 32'(w_ctrl), 32'd0);
    chk("seq_start_low", 32'(start), 32'd0);
    cyc(OP_BIZR, 1'b1, 10'h000, 1'b0);
    chk("bizr_taken", 32'({branch, bizr}), 32'd3);
    cyc(OP_BIZR, 1'b0, 10'h000, 1'b0);
    chk("bizr_not_taken", 32'(w_ctrl), 32'd0);
    cyc(OP_JNZR, 1'b0, 10'h000, 1'b0);
    chk("jnzr_taken", 32'({branch, jnzr}), 32'd3);
    cyc(OP_BNZR, 1'b1, 10'h000, 1'b0);
    chk("bnzr_not_taken", 32'(w_ctrl), 32'd0);
    cyc(OP_JIZR, 1'b1, 10'h000, 1'b0);
    chk("jizr_taken", 32'(jizr), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(4'(7 + i), 1'b0, 10'h000, 1'b0);
      chk("lj_sel", 32'({lj0, lj1, lj2, lj3}), 32'(8 >> i));
    end

    // Call/return with link wrap
    cyc(OP_JSR, 1'b0, 10'h21B, 1'b0);
    chk("jsr1", 32'(jump2sub), 32'd1);
    cyc(OP_JSR, 1'b0, 10'h3FF, 1'b0);
    chk("jsr2", 32'(jump2sub), 32'd1);
    chk("rl_after_jsr1", 32'(rl), 32'h21C);
    cyc(OP_RET, 1'b0, 10'h000, 1'b0);
    chk("ret1_rl", 32'(rl), 32'h000);
    chk("ret1", 32'(retFsub), 32'd1);
    cyc(OP_RET, 1'b0, 10'h000, 1'b0);
    chk("ret2_rl", 32'(rl), 32'h21C);
    chk("ret2", 32'(retFsub), 32'd1);
    cyc(OP_HALT, 1'b0, 10'h000, 1'b0);
    chk("halt_ctrl", 32'(w_ctrl), 32'd0);

    // Done, count of 15 retired ops, relaunch
    cyc(OP_SEQ, 1'b0, 10'h000, 1'b1);
    chk("done", 32'(done), 32'd1);
`ifdef PC_SEQ_INSTR_COUNT_EN
    chk("icount_halt", 32'(instr_count), 32'd15);
`else
    chk("icount_off", 32'(instr_count), 32'd0);
`endif
    cyc(OP_SEQ, 1'b0, 10'h000, 1'b0);
    chk("relaunch_done_low", 32'(done), 32'd0);
    chk("relaunch_start", 32'(start), 32'd1);

    // Overflow
    for (int i = 0; i < 5; i++) begin
      cyc(OP_JSR, 1'b0, 10'(10'h100 + i), 1'b0);
      chk("ovf_jsr", 32'(jump2sub), 32'(i < 4));
    end
    cyc(OP_SEQ, 1'b0, 10'h000, 1'b0);
    chk("ovf_fault", 32'({fault, busy}), 32'd2);

    // Underflow right after relaunch proves sp was cleared
    launch();
    cyc(OP_RET, 1'b0, 10'h000, 1'b0);
    chk("unf_ret", 32'(retFsub), 32'd0);
    cyc(OP_SEQ, 1'b0, 10'h000, 1'b0);
    chk("unf_fault", 32'(fault), 32'd1);

    // Undefined op
    launch();
    cyc(4'd14, 1'b0, 10'h000, 1'b0);
    chk("bad_op_ctrl", 32'(w_ctrl), 32'd0);
    cyc(OP_SEQ, 1'b0, 10'h000, 1'b0);
    chk("bad_op_fault", 32'(fault), 32'd1);

    // Async reset mid-run with two entries stacked
    launch();
    cyc(OP_JSR, 1'b0, 10'h010, 1'b0);
    cyc(OP_JSR, 1'b0, 10'h020, 1'b0);
    cyc(OP_SEQ, 1'b0, 10'h000, 1'b0);
    chk("pre_rst_rl", 32'(rl), 32'h021);
    reset = 1'b1;
    #1;
    chk("arst_ctrl", 32'(w_ctrl), 32'd0);
    chk("arst_rl", 32'(rl), 32'd0);
    chk("arst_status", 32'({busy, done, fault}), 32'd0);
    chk("arst_icount", 32'(instr_count), 32'd0);
    #10 reset = 1'b0;
    cyc(OP_SEQ, 1'b0, 10'h000, 1'b0);
    launch();
    cyc(OP_SEQ, 1'b0, 10'h000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control sequencer for program_counter in the 9-bit CPU.
- Takes the decoded instruction class and the zero flag from the register file each cycle.
- Drives program_counter's one-hot control inputs and supplies its return-link value (rl) from an internal return-address stack.
- Owns the run/halt/fault lifecycle: start pulse, run, halt with done, fault on stack over/underflow.

Parameters:
- RS_DEPTH, 4: return-address stack entries (2..16).
- PC_W, 10: program counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- go  input  1  level; sampled in IDLE/DONE/FAULT to launch a program.
- op_class  input  4  decoded instruction class (pc_seq_pkg::op_class_t).
- zero  input  1  1 when the tested register equals 0.
- rp  input  PC_W  current PC from program_counter.
- start  output  1  program_counter load-start-address strobe.
- branch  output  1  conditional transfer taken.
- bizr, bnzr, jizr, jnzr  output  1 each  conditional mode select; asserted only when taken.
- jump2sub, retFsub  output  1 each  call / return select.
- lj0, lj1, lj2, lj3  output  1 each  long-jump page select.
- rl  output  PC_W  return link, the top of stack.
- busy  output  1  state is START or RUN.
- done  output  1  state is DONE.
- fault  output  1  state is FAULT.
- instr_count  output  16  retired-instruction count (optional feature).

Behaviour:
- Reset state: state=IDLE, sp=0, all stack entries 0, rl=0.
- Reset values of outputs: all control outputs 0, busy=0, done=0, fault=0, instr_count=0.
- Reset is asynchronous and may assert in any state; it aborts in-flight operations with no completion.
- States: IDLE, START, RUN, DONE, FAULT.
- IDLE, DONE, FAULT: on go=1, go to START and clear sp to 0 in the same edge. Otherwise hold.
- START: start=1 for exactly one cycle, then RUN unconditionally. No other control outputs are asserted in START.
- RUN: one instruction per cycle. Outputs are combinational from op_class/zero/sp, so program_counter acts on the next clk edge. go is ignored in RUN.
- Control outputs are mutually exclusive. Either all are 0 (sequential increment) or exactly one mode signal is asserted, plus branch for the conditional forms.
- Decode in RUN:
  - OP_SEQ: all controls 0.
  - OP_BIZR / OP_JIZR: if zero=1, drive branch=1 plus bizr/jizr. Else all controls 0.
  - OP_BNZR / OP_JNZR: if zero=0, drive branch=1 plus bnzr/jnzr. Else all controls 0.
  - OP_LJ0..OP_LJ3: drive the matching ljN=1; unconditional.
  - OP_JSR with sp<RS_DEPTH: drive jump2sub=1, push (rp+1) mod 2^PC_W, sp++. rp=0x3FF pushes 0x000.
  - OP_JSR with sp==RS_DEPTH: jump2sub=0, no push, next state FAULT.
  - OP_RET with sp>0: drive retFsub=1; rl already shows the top entry in that cycle; pop, sp--.
  - OP_RET with sp==0: retFsub=0, next state FAULT.
  - OP_HALT: all controls 0, next state DONE.
  - Undefined encodings (12..15): no controls, next state FAULT.
- rl = stack[sp-1] when sp>0, else 0. rl is combinational from sp and the stack entries.
- In DONE and FAULT all control outputs are 0. The stack contents are retained until the next START, for debug.

Optional Feature:
- Macro PC_SEQ_INSTR_COUNT_EN.
- Defined: instr_count clears to 0 in START. It increments once per RUN cycle whose op completes, including HALT and excluding the faulting op. It saturates at 0xFFFF and holds in DONE/FAULT.
- Undefined: instr_count is tied to 0 and no counter flops are present. The port always exists.

Decomposition:
- pc_seq_pkg holds:
  - op_class_t enum: SEQ=0, BIZR=1, BNZR=2, JIZR=3, JNZR=4, JSR=5, RET=6, LJ0=7, LJ1=8, LJ2=9, LJ3=10, HALT=11.
  - state_t enum.
  - PC_W default.
- One natural sub-module: pc_ret_stack (push, pop, top, sp, full, empty; async reset). The FSM and decode live in pc_sequencer.

Test Plan:
- Launch: reset, go pulse → start=1 for exactly one cycle, busy=1; next cycle with OP_SEQ, all controls 0.
- Conditional decode: OP_BIZR with zero=1 → branch=1, bizr=1. With zero=0 → all controls 0. OP_JNZR with zero=0 → branch=1, jnzr=1.
- Call/return wrap: rp=0x21B, OP_JSR → jump2sub=1. Then rp=0x3FF, OP_JSR → push 0x000. Then OP_RET → rl=0x000, retFsub=1. Then OP_RET → rl=0x21C, retFsub=1.
- Stack overflow: RS_DEPTH=4, five consecutive OP_JSR → first four assert jump2sub. Fifth: jump2sub=0, next cycle fault=1, busy=0.
- Underflow and invalid op: OP_RET with empty stack → fault=1. Separately, op_class=14 → fault=1. In both cases go re-enters START with sp=0.
- Halt, relaunch and reset: OP_HALT → done=1. With the macro defined, instr_count equals the retired ops. go → START and done=0. Async reset mid-RUN with sp=2 → all outputs 0 immediately, rl=0.
